text_console_writer: RTL

- Producer side of the text video RAM: converts a byte-serial character stream (CPU or UART) into writes to the COLS x ROWS character buffer scanned by the text video renderer.
- Keeps a cursor and interprets a small set of control codes.
- Row overflow wraps: the display is a ring of rows, with no scrolling, and every row is blanked on entry.
- Sits between the character source and the RAM write port. The renderer owns the RAM read port.

---
 rtl/console_pkg.sv | 21 ++
 rtl/console_cursor.sv | 63 ++++++
 rtl/text_console_writer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared definitions for the text console writer: control codes, FSM
// state encoding and default screen geometry.
package console_pkg;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam int         DEF_COLS  = 40;
  localparam int         DEF_ROWS  = 15;
  localparam logic [7:0] DEF_BLANK = 8'h20;

  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1,
    WRITE      = 2'd2,
    CLR_LINE   = 2'd3
  } state_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor position for the text console: column/row counters, a row-base
// register stepped by COLS instead of a multiplier, row wrap and the linear
// cell address.
module console_cursor #(
  parameter int A    = 10,
  parameter int COLS = 40,
  parameter int ROWS = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         newline,
  input  logic         cr,
  input  logic         bs,
  input  logic         home,
  output logic [5:0]   col,
  output logic [3:0]   row,
  output logic [A-1:0] row_base,
  output logic [A-1:0] next_base,
  output logic [A-1:0] addr,
  output logic         at_last_col,
  output logic         at_first_col
);

  localparam logic [5:0]   LAST_COL = 6'(COLS - 1);
  localparam logic [3:0]   LAST_ROW = 4'(ROWS - 1);
  localparam logic [A-1:0] ROW_STEP = A'(COLS);

  logic [3:0] next_row;

  // Row wrap and derived addresses
  always_comb begin
    at_last_col  = (col == LAST_COL);
    at_first_col = (col == '0);
    next_row     = (row == LAST_ROW) ? '0 : row + 4'd1;
    next_base    = (row == LAST_ROW) ? '0 : row_base + ROW_STEP;
    addr         = row_base + A'(col);
  end

  // Cursor update; home has priority, then line advance, then column moves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (home) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (newline || (inc && at_last_col)) begin
      col      <= '0;
      row      <= next_row;
      row_base <= next_base;
    end else if (inc) begin
      col <= col + 6'd1;
    end else if (cr) begin
      col <= '0;
    end else if (bs && !at_first_col) begin
      col <= col - 6'd1;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte-serial character stream to text video RAM writer. Interprets
// BS/LF/FF/CR, blanks each row on entry and clears the whole screen after
// reset or form feed.
module text_console_writer
  import console_pkg::*;
#(
  parameter int             A     = 10,
  parameter int             D     = 8,
  parameter int             COLS  = DEF_COLS,
  parameter int             ROWS  = DEF_ROWS,
  parameter logic [D-1:0]   BLANK = D'(DEF_BLANK)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         char_valid,
  input  logic [D-1:0] char_data,
  output logic         char_ready,
  output logic         we,
  output logic [A-1:0] waddr,
  output logic [D-1:0] wdata,
  output logic [5:0]   cursor_col,
  output logic [3:0]   cursor_row,
  output logic         busy
);

  localparam logic [A:0] N_CELLS    = (A + 1)'(COLS * ROWS);
  localparam logic [A:0] LINE_CELLS = (A + 1)'(COLS);

  state_t       state;
  logic [A:0]   cnt;
  logic         adv;
  logic         accept;
  logic         cur_inc;
  logic         cur_newline;
  logic         cur_cr;
  logic         cur_bs;
  logic         cur_home;
  logic [A-1:0] row_base;
  logic [A-1:0] next_base;
  logic [A-1:0] cur_addr;
  logic         at_last_col;
  logic         at_first_col;

  console_cursor #(
    .A    (A),
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk          (clk),
    .reset        (reset),
    .inc          (cur_inc),
    .newline      (cur_newline),
    .cr           (cur_cr),
    .bs           (cur_bs),
    .home         (cur_home),
    .col          (cursor_col),
    .row          (cursor_row),
    .row_base     (row_base),
    .next_base    (next_base),
    .addr         (cur_addr),
    .at_last_col  (at_last_col),
    .at_first_col (at_first_col)
  );

  // Handshake, status and cursor control decode
  always_comb begin
    char_ready  = (state == IDLE);
    busy        = (state == CLR_SCREEN) || (state == CLR_LINE);
    accept      = char_valid && (state == IDLE);
    cur_inc     = (state == WRITE) && adv;
    cur_newline = accept && (char_data == D'(CC_LF));
    cur_cr      = accept && (char_data == D'(CC_CR));
    cur_bs      = accept && (char_data == D'(CC_BS)) && !at_first_col;
    cur_home    = (state == CLR_SCREEN) && (cnt == N_CELLS);
  end

  // FSM and registered RAM write port. A row clear issues its first cell
  // on the entering edge (using next_base, since the cursor row moves on
  // that same edge) so we stays high for exactly COLS cycles in CLR_LINE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLR_SCREEN;
      cnt   <= '0;
      adv   <= 1'b0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= BLANK;
    end else begin
      case (state)
        CLR_SCREEN: begin
          if (cnt == N_CELLS) begin
            we    <= 1'b0;
            state <= IDLE;
          end else begin
            we    <= 1'b1;
            waddr <= cnt[A-1:0];
            wdata <= BLANK;
            cnt   <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (char_valid) begin
            if (char_data == D'(CC_LF)) begin
              we    <= 1'b1;
              waddr <= next_base;
              wdata <= BLANK;
              cnt   <= (A + 1)'(1);
              state <= CLR_LINE;
            end else if (char_data == D'(CC_CR)) begin
              state <= IDLE;
            end else if (char_data == D'(CC_BS)) begin
              if (!at_first_col) begin
                we    <= 1'b1;
                waddr <= cur_addr - A'(1);
                wdata <= BLANK;
                adv   <= 1'b0;
                state <= WRITE;
              end
            end else if (char_data == D'(CC_FF)) begin
              we    <= 1'b1;
              waddr <= '0;
              wdata <= BLANK;
              cnt   <= (A + 1)'(1);
              state <= CLR_SCREEN;
            end else begin
              we    <= 1'b1;
              waddr <= cur_addr;
              wdata <= char_data;
              adv   <= 1'b1;
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (adv && at_last_col) begin
            we    <= 1'b1;
            waddr <= next_base;
            wdata <= BLANK;
            cnt   <= (A + 1)'(1);
            state <= CLR_LINE;
          end else begin
            we    <= 1'b0;
            state <= IDLE;
          end
        end
        CLR_LINE: begin
          if (cnt == LINE_CELLS) begin
            we    <= 1'b0;
            state <= IDLE;
          end else begin
            waddr <= row_base + A'(cnt);
            cnt   <= cnt + 1'b1;
          end
        end
        default: state <= CLR_SCREEN;
      endcase
    end
  end

endmodule
